// File: rtl/mem_arbiter_pkg.sv
// Shared SRAM bus definitions: operation codes, default bus widths and arbiter FSM encodings.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

    localparam logic RAM_OP_RD = 1'b0;
    localparam logic RAM_OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if_buf.sv
// Single-entry instruction buffer (tag/data/valid) with combinational hit compare.
// Fill wins over invalidate; the arbiter never asserts both in one cycle.
module if_buf #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_inv,
    input  logic [ADDR_W-1:0] i_inv_addr,
    input  logic [ADDR_W-1:0] i_look_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic              r_vld;
    logic [ADDR_W-1:0] r_tag;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_vld  <= 1'b0;
            r_tag  <= '0;
            r_data <= '0;
        end else if (i_fill) begin
            r_vld  <= 1'b1;
            r_tag  <= i_fill_addr;
            r_data <= i_fill_data;
        end else if (i_inv && (i_inv_addr == r_tag)) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_hit  = r_vld && (i_look_addr == r_tag);
    assign o_data = r_data;

endmodule

// File: rtl/mem_arbiter.sv
// IF/MEM arbiter for the single-port SRAM controller; 3-cycle access (1 on IF buffer hit with ARB_IFBUF_EN).
// Requesters are held off via stall until their ack; MEM wins in IDLE, ports alternate from RESP.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ram_en,
    output logic              ram_op,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall
);

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic              r_ram_op;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    logic              w_grant;
    logic              w_grant_own;
    logic              w_hit_go;
    logic              w_hit;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_ram_en;
    logic              w_if_ack;
    logic              w_mem_ack;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RESP only looks at the other port: the current owner's req is still its finished request.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_own = OWN_IF;
        w_hit_go    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_grant     = 1'b1;
                    w_grant_own = OWN_MEM;
                    w_state_nxt = ACC1;
                end else if (if_req && w_hit) begin
                    w_hit_go    = 1'b1;
                    w_state_nxt = RESP;
                end else if (if_req) begin
                    w_grant     = 1'b1;
                    w_grant_own = OWN_IF;
                    w_state_nxt = ACC1;
                end
            end
            ACC1: w_state_nxt = ACC2;
            ACC2: w_state_nxt = RESP;
            RESP: begin
                w_state_nxt = IDLE;
                if ((r_owner == OWN_IF) && mem_req) begin
                    w_grant     = 1'b1;
                    w_grant_own = OWN_MEM;
                    w_state_nxt = ACC1;
                end else if ((r_owner == OWN_MEM) && if_req) begin
                    w_grant     = 1'b1;
                    w_grant_own = OWN_IF;
                    w_state_nxt = ACC1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ram_en  = (r_state == ACC1);
        w_if_ack  = (r_state == RESP) && (r_owner == OWN_IF);
        w_mem_ack = (r_state == RESP) && (r_owner == OWN_MEM);
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_owner     <= OWN_IF;
            r_ram_op    <= RAM_OP_RD;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner     <= w_grant_own;
                r_ram_op    <= (w_grant_own == OWN_MEM) ? mem_op : RAM_OP_RD;
                r_ram_addr  <= (w_grant_own == OWN_MEM) ? mem_addr : if_addr;
                r_ram_wdata <= (w_grant_own == OWN_MEM) ? mem_wdata : '0;
            end
            if (w_hit_go) begin
                r_owner    <= OWN_IF;
                r_if_rdata <= w_buf_data;
            end
            if ((r_state == ACC2) && (r_ram_op == RAM_OP_RD)) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= ram_rdata;
                end else begin
                    r_mem_rdata <= ram_rdata;
                end
            end
        end
    end

`ifdef ARB_IFBUF_EN
    logic w_buf_fill;
    logic w_buf_inv;

    assign w_buf_fill = (r_state == ACC2) && (r_owner == OWN_IF);
    assign w_buf_inv  = (r_state == RESP) && (r_owner == OWN_MEM) && (r_ram_op == RAM_OP_WR);

    if_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_buf (
        .clk_50MHz   (clk_50MHz),
        .rst         (rst),
        .i_fill      (w_buf_fill),
        .i_fill_addr (r_ram_addr),
        .i_fill_data (ram_rdata),
        .i_inv       (w_buf_inv),
        .i_inv_addr  (r_ram_addr),
        .i_look_addr (if_addr),
        .o_hit       (w_hit),
        .o_data      (w_buf_data)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    assign ram_en    = w_ram_en;
    assign ram_op    = r_ram_op;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign if_ack    = w_if_ack;
    assign mem_ack   = w_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign stall     = (if_req & ~w_if_ack) | (mem_req & ~w_mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural SRAM behind the controller port.
module tb_mem_arbiter;

    logic        clk_50MHz;
    logic        rst;
    logic        if_req;
    logic [17:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_op;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        ram_en;
    logic        ram_op;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        stall;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int en_wide = 0;
    logic en_prev = 1'b0;

    logic [15:0]   sram [0:1023];
    logic [1023:0] sram_v = '0;

    mem_arbiter #(.ADDR_W(18), .DATA_W(16)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .mem_req   (mem_req),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ram_en    (ram_en),
        .ram_op    (ram_op),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .stall     (stall)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    // Unwritten locations read back as 0xC000 | low address bits.
    always @(posedge clk_50MHz) begin
        if (ram_en && ram_op) begin
            sram[ram_addr[9:0]]   <= ram_wdata;
            sram_v[ram_addr[9:0]] <= 1'b1;
        end
        if (ram_en) en_cnt <= en_cnt + 1;
        if (ram_en && en_prev) en_wide <= en_wide + 1;
        en_prev <= ram_en;
    end

    always_comb begin
        ram_rdata = 16'hC000 | {6'd0, ram_addr[9:0]};
        if (sram_v[ram_addr[9:0]]) ram_rdata = sram[ram_addr[9:0]];
    end

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, waits (bounded) for its ack, then releases the request.
    task automatic access(input bit is_mem, input logic op, input logic [17:0] addr,
                          input logic [15:0] wdata, output int lat, output logic [15:0] rd);
        bit done;
        lat  = -1;
        rd   = 16'hxxxx;
        done = 1'b0;
        if (is_mem) begin
            mem_req = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 1; i <= 10; i++) begin
            if (!done) begin
                step();
                if (is_mem ? mem_ack : if_ack) begin
                    lat  = i;
                    rd   = is_mem ? mem_rdata : if_rdata;
                    done = 1'b1;
                end
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        int          e0;

        rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
        mem_op = 1'b0; mem_addr = '0; mem_wdata = '0;
        step();
        step();
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_op", ram_op, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_acks", {if_ack, mem_ack}, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b1;
        step();

        // MEM write 0x0012A <- 0xBEEF, stepped by hand to watch the held bus
        mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h0012A; mem_wdata = 16'hBEEF;
        #1;
        chk("wr_stall_c0", stall, 1);
        step();
        chk("wr_c1_en", ram_en, 1);
        chk("wr_c1_bus", {ram_op, ram_addr, ram_wdata}, {1'b1, 18'h0012A, 16'hBEEF});
        step();
        chk("wr_c2_en", ram_en, 0);
        chk("wr_c2_bus", {ram_op, ram_addr, ram_wdata}, {1'b1, 18'h0012A, 16'hBEEF});
        chk("wr_c2_ack", mem_ack, 0);
        step();
        chk("wr_c3_ack", mem_ack, 1);
        chk("wr_c3_stall", stall, 0);
        chk("wr_rdata_kept", mem_rdata, 16'h0000);
        mem_req = 1'b0;
        step();
        chk("wr_en_cnt", en_cnt, 1);

        access(1'b1, 1'b0, 18'h0012A, 16'h0000, lat, rd);
        chk("rd_lat", lat, 3);
        chk("rd_data", rd, 16'hBEEF);
        chk("rd_en_cnt", en_cnt, 2);

        // Simultaneous IF 0x20 and MEM 0x12A: MEM acks in cycle 3, IF in cycle 6
        if_req = 1'b1; if_addr = 18'h00020;
        mem_req = 1'b1; mem_op = 1'b0; mem_addr = 18'h0012A;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("sim_c%0d_stall", c), stall, (c < 6) ? 1 : 0);
            chk($sformatf("sim_c%0d_acks", c), {mem_ack, if_ack}, {c == 3, c == 6});
            chk($sformatf("sim_c%0d_en", c), ram_en, (c == 1 || c == 4) ? 1 : 0);
            if (c == 3) begin
                chk("sim_mem_rdata", mem_rdata, 16'hBEEF);
                mem_req = 1'b0;
            end
            if (c == 4) chk("sim_if_bus", {ram_op, ram_addr}, {1'b0, 18'h00020});
            if (c == 6) chk("sim_if_rdata", if_rdata, 16'hC020);
        end
        if_req = 1'b0;
        step();

        // Both ports held for 12 cycles: MEM, IF, MEM, IF
        if_req = 1'b1; if_addr = 18'h00030;
        mem_req = 1'b1; mem_op = 1'b0; mem_addr = 18'h0012A;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk($sformatf("alt_c%0d_acks", c), {mem_ack, if_ack},
                {(c == 3 || c == 9), (c == 6 || c == 12)});
            chk($sformatf("alt_c%0d_en", c), ram_en, (c % 3 == 1) ? 1 : 0);
        end
        chk("alt_if_rdata", if_rdata, 16'hC030);
        if_req = 1'b0; mem_req = 1'b0;
        step();
        chk("en_one_cycle", en_wide, 0);

        // Reset asserted during ACC2 of a write
        mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h00040; mem_wdata = 16'h1234;
        step();
        chk("rst_acc1_en", ram_en, 1);
        step();
        chk("rst_acc2_en", ram_en, 0);
        rst = 1'b0;
        #1;
        chk("rst_mid_bus", {ram_en, ram_op, ram_addr, ram_wdata}, 0);
        chk("rst_mid_out", {if_ack, mem_ack, if_rdata, mem_rdata}, 0);
        mem_req = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("rst_post_c%0d", c), {ram_en, mem_ack, if_ack}, 0);
        end
        access(1'b1, 1'b0, 18'h0012A, 16'h0000, lat, rd);
        chk("rst_idle_lat", lat, 3);
        chk("rst_idle_data", rd, 16'hBEEF);

        access(1'b0, 1'b0, 18'h00010, 16'h0000, lat, rd);
        chk("if1_lat", lat, 3);
        chk("if1_data", rd, 16'hC010);
`ifdef ARB_IFBUF_EN
        e0 = en_cnt;
        access(1'b0, 1'b0, 18'h00010, 16'h0000, lat, rd);
        chk("hit_lat", lat, 1);
        chk("hit_data", rd, 16'hC010);
        chk("hit_no_en", en_cnt, e0);
        access(1'b1, 1'b1, 18'h00010, 16'h7777, lat, rd);
        chk("inv_wr_lat", lat, 3);
        e0 = en_cnt;
        access(1'b0, 1'b0, 18'h00010, 16'h0000, lat, rd);
        chk("inv_if_lat", lat, 3);
        chk("inv_if_data", rd, 16'h7777);
        chk("inv_if_en", en_cnt, e0 + 1);
`else
        e0 = en_cnt;
        access(1'b0, 1'b0, 18'h00010, 16'h0000, lat, rd);
        chk("if2_lat", lat, 3);
        chk("if2_data", rd, 16'hC010);
        chk("if2_en", en_cnt, e0 + 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
